// File: rtl/vram_arbiter.sv
// Single-port video memory arbiter: video reads have priority, a starvation counter forces CPU grants.
// Optional underrun reporting (vid_underrun, underrun_cnt) is built when VRAM_ARB_UNDERRUN_EN is defined.
module vram_arbiter #(
   parameter int AW           = 22,
   parameter int DW           = 16,
   parameter int MEM_LAT      = 1,
   parameter int CPU_MAX_WAIT = 8
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          vid_req,
   input  logic [AW-1:0] vid_addr,
   output logic          vid_ack,
   output logic [DW-1:0] vid_data,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic          cpu_ack,
   output logic [DW-1:0] cpu_rdata,
   output logic [AW-1:0] mem_addr,
   output logic          mem_rden,
   output logic          mem_wren,
   output logic [DW-1:0] mem_dw,
   input  logic [DW-1:0] mem_dr,
   output logic          busy
`ifdef VRAM_ARB_UNDERRUN_EN
   ,
   output logic          vid_underrun,
   output logic [15:0]   underrun_cnt
`endif
);

   localparam int SW = $clog2(CPU_MAX_WAIT + 1);
   localparam int LW = $clog2(MEM_LAT + 1);
   localparam logic [SW-1:0] STARVE_MAX = SW'(CPU_MAX_WAIT);
   localparam logic [LW-1:0] LAT_LAST   = LW'(MEM_LAT - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   state_t        state;
   state_t        state_next;
   logic          owner_cpu;
   logic          owner_we;
   logic [LW-1:0] lat_cnt;
   logic [SW-1:0] starve_cnt;
   logic          grant_cpu;
   logic          grant_vid;

   // Grants are only acted upon while IDLE; the starvation override lets the CPU jump a waiting video request.
   assign grant_cpu = cpu_req && (!vid_req || (starve_cnt == STARVE_MAX));
   assign grant_vid = vid_req && !grant_cpu;

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      busy       = 1'b0;
      mem_rden   = 1'b0;
      mem_wren   = 1'b0;
      vid_ack    = 1'b0;
      cpu_ack    = 1'b0;
      case (state)
         IDLE: begin
            if (grant_cpu || grant_vid) begin
               state_next = ISSUE;
            end
         end
         ISSUE: begin
            busy       = 1'b1;
            mem_rden   = !owner_we;
            mem_wren   = owner_we;
            state_next = owner_we ? DONE : WAIT;
         end
         WAIT: begin
            busy = 1'b1;
            if (lat_cnt == LAT_LAST) begin
               state_next = DONE;
            end
         end
         DONE: begin
            busy       = 1'b1;
            vid_ack    = !owner_cpu;
            cpu_ack    = owner_cpu;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Owner, address and write data are captured once at grant and held for the whole transaction.
   always_ff @(posedge clock) begin
      if (reset) begin
         owner_cpu  <= 1'b0;
         owner_we   <= 1'b0;
         mem_addr   <= '0;
         mem_dw     <= '0;
         lat_cnt    <= '0;
         starve_cnt <= '0;
         vid_data   <= '0;
         cpu_rdata  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_cpu) begin
                  owner_cpu  <= 1'b1;
                  owner_we   <= cpu_we;
                  mem_addr   <= cpu_addr;
                  starve_cnt <= '0;
                  if (cpu_we) begin
                     mem_dw <= cpu_wdata;
                  end
               end else if (grant_vid) begin
                  owner_cpu  <= 1'b0;
                  owner_we   <= 1'b0;
                  mem_addr   <= vid_addr;
                  if (!cpu_req) begin
                     starve_cnt <= '0;
                  end else if (starve_cnt != STARVE_MAX) begin
                     starve_cnt <= starve_cnt + 1'b1;
                  end
               end else begin
                  starve_cnt <= '0;
               end
            end
            ISSUE: lat_cnt <= '0;
            WAIT: begin
               lat_cnt <= lat_cnt + 1'b1;
               if (lat_cnt == LAT_LAST) begin
                  if (owner_cpu) begin
                     cpu_rdata <= mem_dr;
                  end else begin
                     vid_data <= mem_dr;
                  end
               end
            end
            default: ;
         endcase
      end
   end

`ifdef VRAM_ARB_UNDERRUN_EN
   // A video request losing to the starvation override counts as a scan-out underrun.
   assign vid_underrun = (state == IDLE) && vid_req && grant_cpu;

   always_ff @(posedge clock) begin
      if (reset) begin
         underrun_cnt <= '0;
      end else if (vid_underrun && (underrun_cnt != 16'hFFFF)) begin
         underrun_cnt <= underrun_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Randomized bench for vram_arbiter: a transaction-timeline reference model plus a directed MEM_LAT=3 read.
// Underrun outputs are checked when VRAM_ARB_UNDERRUN_EN is defined.
module tb_vram_arbiter;

   localparam int AW   = 22;
   localparam int DW   = 16;
   localparam int LAT  = 1;
   localparam int MAXW = 8;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic          reset = 1'b1;
   logic          vid_req = 1'b0, cpu_req = 1'b0, cpu_we = 1'b0;
   logic [AW-1:0] vid_addr = '0, cpu_addr = '0;
   logic [DW-1:0] cpu_wdata = '0, mem_dr = '0;
   logic          vid_ack, cpu_ack, mem_rden, mem_wren, busy;
   logic [DW-1:0] vid_data, cpu_rdata, mem_dw;
   logic [AW-1:0] mem_addr;

   logic          s_reset = 1'b1;
   logic          s_cpu_req = 1'b0;
   logic [AW-1:0] s_cpu_addr = '0;
   logic [DW-1:0] s_mem_dr = '0;
   logic          s_vid_ack, s_cpu_ack, s_mem_rden, s_mem_wren, s_busy;
   logic [DW-1:0] s_vid_data, s_cpu_rdata, s_mem_dw;
   logic [AW-1:0] s_mem_addr;

`ifdef VRAM_ARB_UNDERRUN_EN
   logic          vid_underrun, s_vid_underrun;
   logic [15:0]   underrun_cnt, s_underrun_cnt;
`endif

   vram_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(LAT), .CPU_MAX_WAIT(MAXW)) dut (
      .clock(clock), .reset(reset),
      .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_data(vid_data),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
      .mem_addr(mem_addr), .mem_rden(mem_rden), .mem_wren(mem_wren), .mem_dw(mem_dw),
      .mem_dr(mem_dr), .busy(busy)
`ifdef VRAM_ARB_UNDERRUN_EN
      , .vid_underrun(vid_underrun), .underrun_cnt(underrun_cnt)
`endif
   );

   vram_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(3), .CPU_MAX_WAIT(MAXW)) dut3 (
      .clock(clock), .reset(s_reset),
      .vid_req(1'b0), .vid_addr('0), .vid_ack(s_vid_ack), .vid_data(s_vid_data),
      .cpu_req(s_cpu_req), .cpu_we(1'b0), .cpu_addr(s_cpu_addr), .cpu_wdata('0),
      .cpu_ack(s_cpu_ack), .cpu_rdata(s_cpu_rdata),
      .mem_addr(s_mem_addr), .mem_rden(s_mem_rden), .mem_wren(s_mem_wren), .mem_dw(s_mem_dw),
      .mem_dr(s_mem_dr), .busy(s_busy)
`ifdef VRAM_ARB_UNDERRUN_EN
      , .vid_underrun(s_vid_underrun), .underrun_cnt(s_underrun_cnt)
`endif
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   logic [AW-1:0] addr_pool [8] = '{22'h000123, 22'h3FFFFF, 22'h000000, 22'h000001,
                                    22'h155555, 22'h2AAAAA, 22'h001000, 22'h3FFFFE};

   // Memory seen by the arbiter (environment) and the model's own shadow of what it should hold.
   logic [DW-1:0] resp_mem [logic [AW-1:0]];
   logic [DW-1:0] ref_mem  [logic [AW-1:0]];
   int            rd_due = -1;
   logic [AW-1:0] rd_addr = '0;

   // Reference model: k counts cycles since the grant cycle (-1 = idle), ISSUE is k=1.
   int            k = -1;
   int            ack_at = 0;
   logic          m_cpu = 1'b0, m_we = 1'b0;
   logic [AW-1:0] m_addr = '0;
   logic [DW-1:0] m_wdata = '0;
   int            starve = 0;
   int            exp_ucnt = 0;
   logic [DW-1:0] exp_vid_data = '0, exp_cpu_rdata = '0;
   bit            fresh_rst = 1'b1;
   bit            vid_acked = 1'b0, cpu_acked = 1'b0;

   function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
      return a[15:0] ^ 16'hC3A5;
   endfunction

   function automatic logic [DW-1:0] resp_rd(input logic [AW-1:0] a);
      if (resp_mem.exists(a)) return resp_mem[a];
      return init_word(a);
   endfunction

   function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
      if (ref_mem.exists(a)) return ref_mem[a];
      return init_word(a);
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s at cycle %0d: got %h expected %h", tag, cyc, observed, expected);
      end
   endtask

   // One clock per iteration: drive after the edge, check and advance the model on the falling edge.
   task automatic applyStimulus(input int n, input int vid_pct, input int cpu_pct,
                                input int rst_pm, input int wr_pct);
      bit gc, gv, und;
      for (int i = 0; i < n; i++) begin
         @(posedge clock);
         #1;
         cyc++;
         reset = ($urandom_range(0, 999) < rst_pm);
         if (!vid_req || vid_acked) begin
            vid_req  = ($urandom_range(0, 99) < vid_pct);
            vid_addr = addr_pool[$urandom_range(0, 7)];
         end
         if (!cpu_req || cpu_acked) begin
            cpu_req   = ($urandom_range(0, 99) < cpu_pct);
            cpu_we    = ($urandom_range(0, 99) < wr_pct);
            cpu_addr  = addr_pool[$urandom_range(0, 7)];
            cpu_wdata = 16'($urandom_range(0, 16'hFFFF));
         end
         mem_dr = (cyc == rd_due) ? resp_rd(rd_addr) : 16'($urandom_range(0, 16'hFFFF));
         @(negedge clock);

         gc  = (k < 0) && cpu_req && (!vid_req || starve == MAXW);
         gv  = (k < 0) && vid_req && !gc;
         und = (k < 0) && vid_req && cpu_req && (starve == MAXW);
         checkOutput("busy", 32'(busy), 32'(k >= 1));
         checkOutput("mem_rden", 32'(mem_rden), 32'(k == 1 && !m_we));
         checkOutput("mem_wren", 32'(mem_wren), 32'(k == 1 && m_we));
         checkOutput("vid_ack", 32'(vid_ack), 32'(k >= 1 && k == ack_at && !m_cpu));
         checkOutput("cpu_ack", 32'(cpu_ack), 32'(k >= 1 && k == ack_at && m_cpu));
         checkOutput("vid_data", 32'(vid_data), 32'(exp_vid_data));
         checkOutput("cpu_rdata", 32'(cpu_rdata), 32'(exp_cpu_rdata));
         if (k >= 1) checkOutput("mem_addr", 32'(mem_addr), 32'(m_addr));
         if (k == 1 && m_we) checkOutput("mem_dw", 32'(mem_dw), 32'(m_wdata));
         if (k < 0 && fresh_rst) begin
            checkOutput("mem_addr_rst", 32'(mem_addr), 32'h0);
            checkOutput("mem_dw_rst", 32'(mem_dw), 32'h0);
         end
`ifdef VRAM_ARB_UNDERRUN_EN
         checkOutput("vid_underrun", 32'(vid_underrun), 32'(und));
         checkOutput("underrun_cnt", 32'(underrun_cnt), 32'(exp_ucnt));
`endif

         if (mem_rden) begin
            rd_due  = cyc + LAT;
            rd_addr = mem_addr;
         end
         if (mem_wren) resp_mem[mem_addr] = mem_dw;
         vid_acked = vid_ack;
         cpu_acked = cpu_ack;

         if (k == 1 && m_we) ref_mem[m_addr] = m_wdata;
         if (reset) begin
            k = -1; starve = 0; exp_ucnt = 0;
            exp_vid_data = '0; exp_cpu_rdata = '0; fresh_rst = 1'b1;
         end else if (k < 0) begin
            if (und && exp_ucnt < 16'hFFFF) exp_ucnt++;
            if (gc) begin
               m_cpu = 1'b1; m_we = cpu_we; m_addr = cpu_addr; m_wdata = cpu_wdata;
               starve = 0;
            end else if (gv) begin
               m_cpu = 1'b0; m_we = 1'b0; m_addr = vid_addr;
               starve = cpu_req ? ((starve < MAXW) ? starve + 1 : MAXW) : 0;
            end else begin
               starve = 0;
            end
            if (gc || gv) begin
               k = 1;
               ack_at = m_we ? 2 : 2 + LAT;
               fresh_rst = 1'b0;
            end
         end else begin
            if (!m_we && k == 1 + LAT) begin
               if (m_cpu) exp_cpu_rdata = ref_rd(m_addr);
               else       exp_vid_data  = ref_rd(m_addr);
            end
            k = (k == ack_at) ? -1 : k + 1;
         end
      end
   endtask

   // CPU read on a MEM_LAT=3 instance with read data present only in cycle 4.
   task automatic runLat3Read();
      @(posedge clock);
      #1;
      s_reset = 1'b0;
      for (int c = 0; c < 9; c++) begin
         @(posedge clock);
         #1;
         s_cpu_req  = (c <= 5);
         s_cpu_addr = 22'h00ABCD;
         s_mem_dr   = (c == 4) ? 16'h07E0 : 16'h0000;
         @(negedge clock);
         checkOutput("lat3_rden", 32'(s_mem_rden), 32'(c == 1));
         checkOutput("lat3_wren", 32'(s_mem_wren), 32'h0);
         checkOutput("lat3_cpu_ack", 32'(s_cpu_ack), 32'(c == 5));
         checkOutput("lat3_vid_ack", 32'(s_vid_ack), 32'h0);
         checkOutput("lat3_busy", 32'(s_busy), 32'(c >= 1 && c <= 5));
         checkOutput("lat3_cpu_rdata", 32'(s_cpu_rdata), (c >= 5) ? 32'h07E0 : 32'h0);
         if (c >= 1 && c <= 5) checkOutput("lat3_mem_addr", 32'(s_mem_addr), 32'h00ABCD);
      end
   endtask

   initial begin
      applyStimulus(4, 0, 0, 1000, 0);
      applyStimulus(200, 100, 0, 0, 0);
      applyStimulus(300, 0, 70, 0, 50);
      applyStimulus(600, 100, 100, 0, 50);
      applyStimulus(1500, 60, 45, 0, 50);
      applyStimulus(1500, 70, 60, 15, 50);
      applyStimulus(4, 0, 0, 1000, 0);
      runLat3Read();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
